// File: rtl/lynx_pkg.sv
// Shared types for the Lynx external SRAM arbiter: cycle-engine states, port ownership
// and the alternating-priority pick used at grant time.
package lynx_pkg;

  localparam int LYNX_RAM_AW = 21;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} arb_state_t;
  typedef enum logic {OWN_C, OWN_V} owner_t;

  // With both ports asking, the one not served last wins; otherwise the lone requester.
  function automatic owner_t arb_pick(input logic c_req, input logic v_req, input owner_t last);
    if (c_req && v_req) return (last == OWN_C) ? OWN_V : OWN_C;
    else if (v_req)     return OWN_V;
    else                return OWN_C;
  endfunction

endpackage

// File: rtl/lynx_sram_cycle.sv
// SRAM cycle timing engine: SETUP (1) / STROBE (WS) / HOLD (1), with read capture on the
// edge entering HOLD. A start seen in HOLD chains straight into the next SETUP.
module lynx_sram_cycle
  import lynx_pkg::*;
#(
  parameter int AW = LYNX_RAM_AW,
  parameter int WS = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    data,
  input  logic [7:0]    ramDi,
  output logic          busy,
  output logic          done,
  output logic          wr,
  output logic [7:0]    rdata,
  output logic [AW-1:0] ramA,
  output logic          ramWe,
  output logic [7:0]    ramDo,
  output logic          ramDoEn
);

  localparam logic [2:0] WS_M1 = 3'(WS - 1);

  arb_state_t    state_q, state_n;
  logic [2:0]    cnt_q, cnt_n;
  logic          wr_q;
  logic [AW-1:0] ramA_q;
  logic [7:0]    ramDo_q;
  logic [7:0]    rdata_q;
  logic          accept;

  assign accept = start && (state_q == IDLE || state_q == HOLD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      ramA_q  <= '0;
      ramDo_q <= 8'h00;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      // Address and write data only move at a grant, never while WE is low.
      if (accept) begin
        ramA_q  <= addr;
        ramDo_q <= data;
        wr_q    <= we;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == STROBE && cnt_q == 3'd0 && !wr_q) rdata_q <= ramDi;
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE:   if (start) state_n = SETUP;
      SETUP: begin
        state_n = STROBE;
        cnt_n   = WS_M1;
      end
      STROBE: begin
        if (cnt_q == 3'd0) state_n = HOLD;
        else               cnt_n   = cnt_q - 3'd1;
      end
      HOLD:   state_n = start ? SETUP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == HOLD);
    ramWe   = !(state_q == STROBE && wr_q);
    ramDoEn = (state_q != IDLE) && wr_q;
  end

  assign wr    = wr_q;
  assign rdata = rdata_q;
  assign ramA  = ramA_q;
  assign ramDo = ramDo_q;

endmodule

// File: rtl/lynx_sram_arb.sv
// Two-port (CPU / video) arbiter for the external 8-bit async SRAM.
// Optional build macro LYNX_ARB_STATS_EN adds the statCWait CPU wait counter.
module lynx_sram_arb
  import lynx_pkg::*;
#(
  parameter int AW = LYNX_RAM_AW,
  parameter int WS = 1
) (
`ifdef LYNX_ARB_STATS_EN
  output logic [15:0]   statCWait,
`endif
  input  logic          clock,
  input  logic          reset,
  input  logic          cReq,
  input  logic          cWe,
  input  logic [AW-1:0] cA,
  input  logic [7:0]    cDi,
  output logic [7:0]    cDo,
  output logic          cAck,
  input  logic          vReq,
  input  logic [AW-1:0] vA,
  output logic [7:0]    vDo,
  output logic          vAck,
  output logic [AW-1:0] ramA,
  output logic          ramWe,
  output logic [7:0]    ramDo,
  output logic          ramDoEn,
  input  logic [7:0]    ramDi
);

  logic       busy, done, wr;
  logic [7:0] rdata;
  owner_t     owner_q;
  owner_t     gsel;
  logic       c_req_m, v_req_m, grant;
  logic [7:0] cDo_q, vDo_q;

  // The port being acked still holds its request this cycle, so it is masked out.
  assign c_req_m = cReq && !(done && owner_q == OWN_C);
  assign v_req_m = vReq && !(done && owner_q == OWN_V);
  assign gsel    = arb_pick(c_req_m, v_req_m, owner_q);
  assign grant   = (!busy || done) && (c_req_m || v_req_m);

  lynx_sram_cycle #(.AW(AW), .WS(WS)) u_cycle (
    .clock   (clock),
    .reset   (reset),
    .start   (grant),
    .we      (gsel == OWN_C && cWe),
    .addr    ((gsel == OWN_C) ? cA : vA),
    .data    (cDi),
    .ramDi   (ramDi),
    .busy    (busy),
    .done    (done),
    .wr      (wr),
    .rdata   (rdata),
    .ramA    (ramA),
    .ramWe   (ramWe),
    .ramDo   (ramDo),
    .ramDoEn (ramDoEn)
  );

  // owner_q is also the 'last served' register: it only changes on a grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= OWN_C;
      cDo_q   <= 8'hFF;
      vDo_q   <= 8'hFF;
    end else begin
      if (grant) owner_q <= gsel;
      if (done && !wr) begin
        if (owner_q == OWN_C) cDo_q <= rdata;
        else                  vDo_q <= rdata;
      end
    end
  end

  assign cAck = done && owner_q == OWN_C;
  assign vAck = done && owner_q == OWN_V;
  assign cDo  = (cAck && !wr) ? rdata : cDo_q;
  assign vDo  = (vAck && !wr) ? rdata : vDo_q;

`ifdef LYNX_ARB_STATS_EN
  logic c_active;
  assign c_active = (busy && owner_q == OWN_C) || (grant && gsel == OWN_C);

  always_ff @(posedge clock) begin
    if (reset)                                     statCWait <= 16'h0000;
    else if (cReq && !c_active && statCWait != 16'hFFFF) statCWait <= statCWait + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_lynx_sram_arb.sv
// Directed bench for lynx_sram_arb with an ack scoreboard and a small SRAM model.
module tb_lynx_sram_arb;

  localparam int AW = 21;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cReq = 1'b0, cWe = 1'b0, vReq = 1'b0;
  logic [AW-1:0] cA = '0, vA = '0;
  logic [7:0]    cDi = 8'h00;
  logic [7:0]    cDo, vDo, ramDo, ramDi;
  logic          cAck, vAck, ramWe, ramDoEn;
  logic [AW-1:0] ramA;
`ifdef LYNX_ARB_STATS_EN
  logic [15:0]   statCWait;
`endif

  int vec  = 0;
  int miss = 0;

  typedef struct {
    logic       port;   // 0 = C, 1 = V
    logic       rd;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] mem [0:4095];

  lynx_sram_arb #(.AW(AW), .WS(1)) dut (
`ifdef LYNX_ARB_STATS_EN
    .statCWait (statCWait),
`endif
    .clock   (clock),
    .reset   (reset),
    .cReq    (cReq),
    .cWe     (cWe),
    .cA      (cA),
    .cDi     (cDi),
    .cDo     (cDo),
    .cAck    (cAck),
    .vReq    (vReq),
    .vA      (vA),
    .vDo     (vDo),
    .vAck    (vAck),
    .ramA    (ramA),
    .ramWe   (ramWe),
    .ramDo   (ramDo),
    .ramDoEn (ramDoEn),
    .ramDi   (ramDi)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
  end

  always @(posedge clock) if (!ramWe && ramDoEn) mem[ramA[11:0]] <= ramDo;
  assign ramDi = mem[ramA[11:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (cAck || vAck) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack", {30'd0, cAck, vAck}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("ack_port", {30'd0, cAck, vAck}, e.port ? 32'd1 : 32'd2);
        if (e.rd) check("ack_rdata", {24'd0, (vAck ? vDo : cDo)}, {24'd0, e.data});
      end
    end
  end

  task automatic push(input logic port, input logic rd, input logic [7:0] data);
    exp_t e;
    e.port = port; e.rd = rd; e.data = data;
    sbq.push_back(e);
  endtask

  task automatic do_access(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [7:0] data, input logic [7:0] exp_rd);
    bit got;
    @(posedge clock); #1;
    if (port) begin vReq = 1'b1; vA = addr; end
    else begin cReq = 1'b1; cWe = we; cA = addr; cDi = data; end
    push(port, !we, exp_rd);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clock);
      if (port ? vAck : cAck) got = 1;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
    if (port) vReq = 1'b0; else cReq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  t [0:7];
    bit  drop_v;
    bit  got;

    // T1: reset and idle
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ramA", {11'd0, ramA}, 32'd0);
    check("rst_ramDo", {24'd0, ramDo}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("idle_state", {12'd0, ramWe, ramDoEn, cAck, vAck, cDo, vDo}, {12'd0, 4'b1000, 16'hFFFF});
    end

    // T2: CPU write 0x01234 <= A5
    @(posedge clock); #1;
    cReq = 1'b1; cWe = 1'b1; cA = 21'h01234; cDi = 8'hA5;
    push(1'b0, 1'b0, 8'h00);
    @(posedge clock);
    @(negedge clock);
    check("wr_setup", {29'd0, ramWe, ramDoEn, cAck}, 32'b110);
    check("wr_setup_a", {3'd0, ramA, ramDo}, {3'd0, 21'h01234, 8'hA5});
    @(negedge clock);
    check("wr_strobe", {29'd0, ramWe, ramDoEn, cAck}, 32'b010);
    check("wr_strobe_a", {3'd0, ramA, ramDo}, {3'd0, 21'h01234, 8'hA5});
    @(negedge clock);
    check("wr_hold", {29'd0, ramWe, ramDoEn, cAck}, 32'b111);
    check("wr_hold_a", {3'd0, ramA, ramDo}, {3'd0, 21'h01234, 8'hA5});
    @(posedge clock); #1 cReq = 1'b0;
    @(negedge clock);
    check("wr_idle", {29'd0, ramWe, ramDoEn, cAck}, 32'b100);
    check("wr_mem", {24'd0, mem[12'h234]}, 32'hA5);

    // T3: CPU read back, data bus never driven
    @(posedge clock); #1;
    cReq = 1'b1; cWe = 1'b0; cA = 21'h01234;
    push(1'b0, 1'b1, 8'hA5);
    @(posedge clock);
    repeat (3) begin
      @(negedge clock);
      check("rd_doen", {31'd0, ramDoEn}, 32'd0);
    end
    @(posedge clock); #1 cReq = 1'b0;
    @(negedge clock);
    check("rd_cdo_kept", {24'd0, cDo}, 32'hA5);

    // T4: both held from the same edge -> V,C,V,C,V,C with acks 3 cycles apart
    push(1'b1, 1'b1, 8'h4A); push(1'b0, 1'b1, 8'hA5);
    push(1'b1, 1'b1, 8'h4A); push(1'b0, 1'b1, 8'hA5);
    push(1'b1, 1'b1, 8'h4A); push(1'b0, 1'b1, 8'hA5);
    @(posedge clock); #1;
    cReq = 1'b1; cWe = 1'b0; cA = 21'h01234;
    vReq = 1'b1; vA = 21'h00010;
    n = 0; drop_v = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      @(posedge clock); #1;
      if (drop_v) vReq = 1'b0;
      @(negedge clock);
      if (cAck || vAck) begin
        t[n] = k;
        n++;
        if (n == 5) drop_v = 1;
      end
    end
    @(posedge clock); #1 cReq = 1'b0;
    check("alt_count", n, 6);
    for (int i = 0; i < 6; i++) check("alt_timing", t[i], 2 + 3 * i);
    check("vdo_kept", {24'd0, vDo}, 32'h4A);

    // T5: reset during a write's strobe
    @(posedge clock); #1;
    cReq = 1'b1; cWe = 1'b1; cA = 21'h00100; cDi = 8'h77;
    @(posedge clock);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; cReq = 1'b0;
    @(negedge clock);
    check("rst_mid", {29'd0, ramWe, ramDoEn, cAck}, 32'b100);
    check("rst_mid_do", {16'd0, cDo, vDo}, 32'hFFFF);
    repeat (4) @(negedge clock);
    do_access(1'b0, 1'b0, 21'h01234, 8'h00, 8'hA5);
    do_access(1'b1, 1'b0, 21'h00020, 8'h00, 8'h7A);

`ifdef LYNX_ARB_STATS_EN
    // T6: CPU waits behind exactly one video access
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    push(1'b1, 1'b1, 8'h4A); push(1'b0, 1'b1, 8'hA5); push(1'b1, 1'b1, 8'h4A);
    @(posedge clock); #1;
    cReq = 1'b1; cWe = 1'b0; cA = 21'h01234;
    vReq = 1'b1; vA = 21'h00010;
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clock);
      if (cAck) got = 1;
    end
    if (!got) check("stat_cack_timeout", 32'd0, 32'd1);
    @(posedge clock); #1 cReq = 1'b0;
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clock);
      if (vAck) got = 1;
    end
    if (!got) check("stat_vack_timeout", 32'd0, 32'd1);
    @(posedge clock); #1 vReq = 1'b0;
    repeat (3) @(negedge clock);
    check("stat_cwait", {16'd0, statCWait}, 32'd3);
`endif

    repeat (4) @(negedge clock);
    check("sb_empty", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
